// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signal bundle for uart_tx_arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   REQ_VALID;
    logic [8*N-1:0] REQ_DATA;
    logic [N-1:0]   REQ_LAST;
    logic [N-1:0]   REQ_READY;
    logic [N-1:0]   GRANT;
    logic [7:0]     TX_DATA;
    logic           TX_VALID;
    logic           TX_READY;
    logic           BUSY;

    modport slave (
        input  REQ_VALID,
        input  REQ_DATA,
        input  REQ_LAST,
        input  TX_READY,
        output REQ_READY,
        output GRANT,
        output TX_DATA,
        output TX_VALID,
        output BUSY
    );

    modport master (
        output REQ_VALID,
        output REQ_DATA,
        output REQ_LAST,
        output TX_READY,
        input  REQ_READY,
        input  GRANT,
        input  TX_DATA,
        input  TX_VALID,
        input  BUSY
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART byte transmitter among N
// byte-stream requesters, with a one-byte registered output stage.
module uart_tx_arbiter #(
    parameter int N      = 4,
    parameter int MAXLEN = 16,
    parameter int GAP    = 255
) (
    input  logic             CLK,
    input  logic             RESETN,
    uart_tx_arbiter_if.slave bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
    localparam logic [7:0]    MAXLEN_W = 8'(MAXLEN);
    localparam logic [7:0]    GAP_W    = 8'(GAP);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [PW-1:0]  ptr_r, ptr_nxt_s;
    logic [PW-1:0]  owner_r, owner_nxt_s;
    logic [N-1:0]   grant_r, grant_nxt_s;
    logic [7:0]     cnt_r, cnt_nxt_s;
    logic [7:0]     gcnt_r, gcnt_nxt_s;
    logic [7:0]     tx_data_r, tx_data_nxt_s;
    logic           tx_valid_r, tx_valid_nxt_s;

    logic           owner_valid_s;
    logic           owner_last_s;
    logic [7:0]     lane_s;
    logic           accept_s;
    logic           release_s;
    logic [7:0]     cnt_inc_s;
    logic [7:0]     gcnt_inc_s;
    logic [PW-1:0]  pick_s;
    logic [PW-1:0]  ptr_after_s;
    logic [N-1:0]   ready_s;

    // First valid index searching upward from start with wrap; the loop runs
    // from the far end so the nearest offset is assigned last and wins.
    function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] valid,
                                              input logic [PW-1:0] start);
        logic [PW-1:0] pick;
        int            idx;
        pick = start;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N;
            if (valid[idx]) begin
                pick = idx[PW-1:0];
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    assign owner_valid_s = bus.REQ_VALID[owner_r];
    assign owner_last_s  = bus.REQ_LAST[owner_r];
    assign lane_s        = bus.REQ_DATA[{owner_r, 3'b000} +: 8];
    assign pick_s        = rr_pick(bus.REQ_VALID, ptr_r);
    assign ptr_after_s   = (owner_r == LAST_IDX) ? {PW{1'b0}} : owner_r + {{(PW-1){1'b0}}, 1'b1};
    assign cnt_inc_s     = cnt_r + 8'd1;
    assign gcnt_inc_s    = gcnt_r + 8'd1;

    // A byte moves in when the owner offers one and the output slot is free or draining now.
    assign accept_s  = (state_r == ST_XFER) && owner_valid_s && (!tx_valid_r || bus.TX_READY);
    assign release_s = (accept_s && (owner_last_s || (cnt_inc_s == MAXLEN_W))) ||
                       ((state_r == ST_XFER) && !owner_valid_s && (gcnt_inc_s == GAP_W));

    // Only the owner's ready bit can rise, and only on an accept.
    always_comb begin
        ready_s          = {N{1'b0}};
        ready_s[owner_r] = accept_s;
    end

    // Next-state and next-register computation for the arbiter FSM and output stage.
    always_comb begin
        state_nxt_s    = state_r;
        ptr_nxt_s      = ptr_r;
        owner_nxt_s    = owner_r;
        grant_nxt_s    = grant_r;
        cnt_nxt_s      = cnt_r;
        gcnt_nxt_s     = gcnt_r;
        tx_data_nxt_s  = tx_data_r;
        tx_valid_nxt_s = tx_valid_r;

        // The output register drains in either state, so a byte left over
        // from a released packet still reaches the transmitter.
        if (accept_s) begin
            tx_data_nxt_s  = lane_s;
            tx_valid_nxt_s = 1'b1;
        end else if (bus.TX_READY) begin
            tx_valid_nxt_s = 1'b0;
        end else begin
            tx_valid_nxt_s = tx_valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (|bus.REQ_VALID) begin
                    owner_nxt_s = pick_s;
                    grant_nxt_s = {{(N-1){1'b0}}, 1'b1} << pick_s;
                    cnt_nxt_s   = 8'd0;
                    gcnt_nxt_s  = 8'd0;
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (accept_s) begin
                    cnt_nxt_s  = cnt_inc_s;
                    gcnt_nxt_s = 8'd0;
                end else if (!owner_valid_s) begin
                    gcnt_nxt_s = gcnt_inc_s;
                end else begin
                    gcnt_nxt_s = gcnt_r;
                end
                if (release_s) begin
                    grant_nxt_s = {N{1'b0}};
                    ptr_nxt_s   = ptr_after_s;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            default: begin
                grant_nxt_s = {N{1'b0}};
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any buffered byte.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {PW{1'b0}};
            owner_r    <= {PW{1'b0}};
            grant_r    <= {N{1'b0}};
            cnt_r      <= 8'd0;
            gcnt_r     <= 8'd0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            owner_r    <= owner_nxt_s;
            grant_r    <= grant_nxt_s;
            cnt_r      <= cnt_nxt_s;
            gcnt_r     <= gcnt_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
        end
    end

    assign bus.REQ_READY = ready_s;
    assign bus.GRANT     = grant_r;
    assign bus.TX_DATA   = tx_data_r;
    assign bus.TX_VALID  = tx_valid_r;
    assign bus.BUSY      = (state_r != ST_IDLE) || tx_valid_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N=4, MAXLEN=3, GAP=5) with hand-computed
// expectations checked by immediate assertions.
module tb_uart_tx_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    uart_tx_arbiter_if #(.N(4)) bus ();

    uart_tx_arbiter #(.N(4), .MAXLEN(3), .GAP(5)) dut (
        .CLK    (clk),
        .RESETN (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [7:0] d);
        bus.REQ_DATA[8*i +: 8] = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n         = 1'b0;
        bus.REQ_VALID = 4'b0000;
        bus.REQ_DATA  = 32'h0000_0000;
        bus.REQ_LAST  = 4'b0000;
        bus.TX_READY  = 1'b0;
        tick();
        tick();
        chk("rst_grant", bus.GRANT, 4'b0000);
        chk("rst_txvalid", bus.TX_VALID, 1'b0);
        chk("rst_txdata", bus.TX_DATA, 8'h00);
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_ready", bus.REQ_READY, 4'b0000);
        rst_n = 1'b1;
        tick();

        // Single packet from requester 2
        bus.TX_READY  = 1'b1;
        bus.REQ_VALID = 4'b0100;
        set_lane(2, 8'h48);
        #1;
        chk("t1_ready_idle", bus.REQ_READY, 4'b0000);
        tick();
        chk("t1_grant", bus.GRANT, 4'b0100);
        chk("t1_ready_first", bus.REQ_READY, 4'b0100);
        tick();
        chk("t1_data0", bus.TX_DATA, 8'h48);
        chk("t1_valid0", bus.TX_VALID, 1'b1);
        set_lane(2, 8'h69);
        bus.REQ_LAST = 4'b0100;
        #1;
        chk("t1_ready_second", bus.REQ_READY, 4'b0100);
        tick();
        chk("t1_data1", bus.TX_DATA, 8'h69);
        chk("t1_release", bus.GRANT, 4'b0000);
        bus.REQ_VALID = 4'b0000;
        bus.REQ_LAST  = 4'b0000;
        tick();
        chk("t1_drained", bus.TX_VALID, 1'b0);
        chk("t1_busy", bus.BUSY, 1'b0);

        // Round robin: pointer is 3 after requester 2 released
        for (int i = 0; i < 4; i++) set_lane(i, 8'hA0 + 8'(i));
        bus.REQ_LAST  = 4'b1111;
        bus.REQ_VALID = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_grant", bus.GRANT, 32'd1 << ((3 + i) % 4));
            tick();
            chk("rr_gap", bus.GRANT, 4'b0000);
            chk("rr_data", bus.TX_DATA, 32'hA0 + ((3 + i) % 4));
        end
        bus.REQ_VALID = 4'b0000;
        bus.REQ_LAST  = 4'b0000;
        tick();
        chk("rr_drained", bus.TX_VALID, 1'b0);

        // MAXLEN=3: requester 1 streams without LAST, requester 0 waits
        set_lane(1, 8'h11);
        bus.REQ_VALID = 4'b0010;
        tick();
        chk("ml_grant1", bus.GRANT, 4'b0010);
        bus.REQ_VALID = 4'b0011;
        set_lane(0, 8'h55);
        bus.REQ_LAST  = 4'b0001;
        tick();
        chk("ml_d11", bus.TX_DATA, 8'h11);
        set_lane(1, 8'h12);
        tick();
        chk("ml_d12", bus.TX_DATA, 8'h12);
        set_lane(1, 8'h13);
        #1;
        chk("ml_ready_owner_only", bus.REQ_READY, 4'b0010);
        tick();
        chk("ml_d13", bus.TX_DATA, 8'h13);
        chk("ml_forced_release", bus.GRANT, 4'b0000);
        tick();
        chk("ml_wrap_to_0", bus.GRANT, 4'b0001);
        tick();
        chk("ml_d55", bus.TX_DATA, 8'h55);
        chk("ml_release0", bus.GRANT, 4'b0000);
        bus.REQ_VALID = 4'b0010;
        bus.REQ_LAST  = 4'b0000;
        set_lane(1, 8'h14);
        tick();
        chk("ml_regrant1", bus.GRANT, 4'b0010);
        tick();
        chk("ml_d14", bus.TX_DATA, 8'h14);
        set_lane(1, 8'h15);
        bus.REQ_LAST = 4'b0010;
        tick();
        chk("ml_d15", bus.TX_DATA, 8'h15);
        chk("ml_release1", bus.GRANT, 4'b0000);
        bus.REQ_VALID = 4'b0000;
        bus.REQ_LAST  = 4'b0000;
        tick();
        chk("ml_drained", bus.TX_VALID, 1'b0);

        // Backpressure: pointer is 2, transmitter stalled
        bus.TX_READY = 1'b0;
        set_lane(2, 8'h21);
        bus.REQ_VALID = 4'b0100;
        tick();
        chk("bp_grant", bus.GRANT, 4'b0100);
        chk("bp_ready_empty", bus.REQ_READY, 4'b0100);
        tick();
        chk("bp_d21", bus.TX_DATA, 8'h21);
        chk("bp_valid", bus.TX_VALID, 1'b1);
        set_lane(2, 8'h22);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_ready_blocked", bus.REQ_READY, 4'b0000);
            tick();
            chk("bp_hold", bus.TX_DATA, 8'h21);
        end
        bus.TX_READY = 1'b1;
        bus.REQ_LAST = 4'b0100;
        #1;
        chk("bp_ready_pulse", bus.REQ_READY, 4'b0100);
        tick();
        chk("bp_d22", bus.TX_DATA, 8'h22);
        chk("bp_valid_kept", bus.TX_VALID, 1'b1);
        chk("bp_release", bus.GRANT, 4'b0000);
        bus.REQ_VALID = 4'b0000;
        bus.REQ_LAST  = 4'b0000;
        tick();
        chk("bp_drained", bus.TX_VALID, 1'b0);

        // Stall timeout with GAP=5: pointer is 3
        set_lane(3, 8'h31);
        bus.REQ_VALID = 4'b1000;
        tick();
        chk("gap_grant", bus.GRANT, 4'b1000);
        tick();
        chk("gap_d31", bus.TX_DATA, 8'h31);
        bus.REQ_VALID = 4'b0000;
        repeat (4) tick();
        chk("gap_hold_at4", bus.GRANT, 4'b1000);
        set_lane(3, 8'h32);
        bus.REQ_VALID = 4'b1000;
        tick();
        chk("gap_d32", bus.TX_DATA, 8'h32);
        chk("gap_kept", bus.GRANT, 4'b1000);
        bus.REQ_VALID = 4'b0000;
        repeat (4) tick();
        chk("gap_hold_again", bus.GRANT, 4'b1000);
        tick();
        chk("gap_timeout", bus.GRANT, 4'b0000);
        chk("gap_idle", bus.BUSY, 1'b0);

        // Reset mid-transfer with a buffered byte; pointer moved to 1 first
        set_lane(0, 8'h40);
        bus.REQ_LAST  = 4'b0001;
        bus.REQ_VALID = 4'b0001;
        tick();
        chk("rs_grant0", bus.GRANT, 4'b0001);
        tick();
        chk("rs_d40", bus.TX_DATA, 8'h40);
        bus.REQ_VALID = 4'b0100;
        bus.REQ_LAST  = 4'b0000;
        set_lane(2, 8'h41);
        tick();
        chk("rs_grant2", bus.GRANT, 4'b0100);
        bus.TX_READY = 1'b0;
        tick();
        chk("rs_d41", bus.TX_DATA, 8'h41);
        chk("rs_busy", bus.BUSY, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rs_async_grant", bus.GRANT, 4'b0000);
        chk("rs_async_txvalid", bus.TX_VALID, 1'b0);
        chk("rs_async_txdata", bus.TX_DATA, 8'h00);
        chk("rs_async_busy", bus.BUSY, 1'b0);
        chk("rs_async_ready", bus.REQ_READY, 4'b0000);
        bus.REQ_VALID = 4'b1111;
        #1;
        rst_n = 1'b1;
        tick();
        chk("rs_first_grant0", bus.GRANT, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART byte transmitter (the 8N1 baud divider / bit counter / PISO path) among up to N byte-stream requesters. Grants are round-robin with packet lock, so a granted source keeps the line until it signals last, hits a length limit, or stalls too long. Accepted bytes are buffered in a one-byte output register and presented to the transmitter over a valid/ready handshake. The block sits between message sources (ROM sequencers, status reporters) and the UART transmitter in the top-level `main`.

## Interface
- `N`, 4: number of requesters, legal 2..8.
- `MAXLEN`, 16: maximum bytes per grant before forced release, legal 1..255.
- `GAP`, 255: maximum consecutive cycles a granted requester may hold `REQ_VALID` low before forced release, legal 1..255.

- `CLK` input 1: single clock, rising edge. The whole block is in this domain.
- `RESETN` input 1: asynchronous, active-low reset.
- `REQ_VALID` input N: requester i has a byte on its data lane.
- `REQ_DATA` input 8*N: requester i byte on bits [8i+7:8i].
- `REQ_LAST` input N: the byte from requester i is the last of its packet.
- `REQ_READY` output N: the byte from requester i is accepted this cycle.
- `GRANT` output N: one-hot current owner; all zero when idle.
- `TX_DATA` output 8: byte to the UART transmitter.
- `TX_VALID` output 1: `TX_DATA` is valid.
- `TX_READY` input 1: the transmitter loads `TX_DATA` this cycle (its PISO LOAD).
- `BUSY` output 1: high when the state is not IDLE or `TX_VALID` is high.

## Operation
- **State machine:** IDLE and XFER. Registers: `PTR` (log2 N bits), `g` (owner index), `CNT` (8-bit count of bytes accepted this grant), `GCNT` (8-bit stall counter), and the output register `TX_DATA`/`TX_VALID`.
- **IDLE:**
  - If any `REQ_VALID` bit is high, select the first index i, searching from `PTR` upward with wrap mod N.
  - Next cycle: `GRANT` = one-hot(i), g = i, `CNT` = 0, `GCNT` = 0, state = XFER.
  - `REQ_VALID` is sampled only in IDLE; bits that drop before the grant are not remembered.
- **XFER, accept condition:** accept = `REQ_VALID[g]` and (not `TX_VALID` or `TX_READY`).
- **XFER, signals:**
  - `REQ_READY[g]` = accept, combinational. This includes a combinational path from `TX_READY`.
  - Every other `REQ_READY` bit is 0.
- **XFER, on accept:** `TX_DATA` <= lane g, `TX_VALID` <= 1, `CNT` <= `CNT`+1, `GCNT` <= 0.
- **XFER, on TX_READY with no accept:** `TX_VALID` <= 0.
- **XFER, when REQ_VALID[g] is low:** `GCNT` <= `GCNT`+1.
- **Release conditions**, evaluated on the current cycle:
  - accept with `REQ_LAST[g]`;
  - accept with `CNT`+1 == `MAXLEN`;
  - `REQ_VALID[g]` low with `GCNT`+1 == `GAP`.
- **On release:** `GRANT` <= 0, `PTR` <= (g+1) mod N, state <= IDLE. A byte still held in the output register stays valid and drains normally.
- **Arbitration while draining:** IDLE may re-arbitrate while `TX_VALID` is still high. The new owner's first accept waits for `TX_READY`.
- **Width rules:** `CNT` and `GCNT` never exceed their limits (≤255), so they do not wrap.
- **Reset** (any time, including mid-packet): asynchronous, immediately sets
  - state IDLE, `PTR`=0, `GRANT`=0, `TX_VALID`=0, `TX_DATA`=0x00, `CNT`=0, `GCNT`=0.
  - `REQ_READY`=0 and `BUSY`=0 follow combinationally.
  - A buffered byte is discarded.

## Timing
- **Grant latency:** `REQ_VALID` high in IDLE at cycle t gives `GRANT` at t+1. The first accept can occur at t+1; `TX_VALID` rises at t+2.
- **Throughput:** the output register supports back-to-back transfer. Accept and `TX_READY` in the same cycle reload the register, and `TX_VALID` stays high.
- **Packet boundary:** the cycle after a release is IDLE, so there is exactly one bubble cycle between packets at the arbiter. The UART path, paced by its bit timing, hides it.
- **Output stability:** `TX_DATA` and `TX_VALID` are registered. `TX_DATA` is stable while `TX_VALID` is high and `TX_READY` is low.
- **Fairness:** with all N requesters continuously valid, grants rotate 0,1,…,N-1,0.

## Test plan
- **Reset values:** assert `RESETN`=0 mid-XFER with `TX_VALID`=1 → `GRANT`=0, `TX_VALID`=0, `TX_DATA`=0x00, `BUSY`=0 immediately, before the next clock edge. Release reset → first grant goes to index 0.
- **Single packet:** requester 2 sends 0x48,0x69 (`LAST` on 0x69) with `TX_READY` tied 1 → `GRANT`=4'b0100 one cycle after valid. `TX_DATA` shows 0x48 then 0x69 on consecutive cycles, then `GRANT`=0 and `PTR`=3.
- **Round robin:** all 4 requesters valid with 1-byte packets → grant order 0,1,2,3,0; each grant is separated by one IDLE cycle.
- **MAXLEN:** `MAXLEN`=3, requester 1 streams 5 bytes with no `LAST`, requester 0 also valid → 3 bytes accepted, then the grant passes to requester 2 if valid, otherwise wraps to requester 0 (search starts at `PTR`=2). The remaining 2 bytes go out on requester 1's next grant.
- **Backpressure:** `TX_READY` held 0 for 10 cycles with the owner valid → exactly one byte is buffered, `REQ_READY`=0, and `TX_DATA` stays constant. `TX_READY` pulses once → the next byte is accepted that same cycle.
- **Stall timeout:** `GAP`=5, owner drops `REQ_VALID` after 1 byte → release in the 5th low cycle, `GRANT`=0 the next cycle. `REQ_VALID` returning at count 4 resets `GCNT` and keeps the grant.
